// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IFU, LSU and shared memory-port channels around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_req_addr;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_resp_data;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_W-1:0]     lsu_req_wdata;
    logic [DATA_W/8-1:0]   lsu_req_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    logic                  owner;

    modport master (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output owner
    );

    modport slave (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one
// outstanding transaction at a time, response routed back to the issuer.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_req_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                w_idle;
    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_resp;
    logic                w_resp_ifu;
    logic                w_resp_lsu;

    // rst_n gates the combinational handshakes so every output is 0 in reset
    assign w_idle      = rst_n && (r_state == IDLE);
    assign w_grant_ifu = w_idle && bus.ifu_req_valid && (!bus.lsu_req_valid || r_last_grant);
    assign w_grant_lsu = w_idle && bus.lsu_req_valid && (!bus.ifu_req_valid || !r_last_grant);
    assign w_resp      = rst_n && (r_state == WAIT_RESP) && bus.mem_resp_valid;
    assign w_resp_ifu  = w_resp && !r_owner;
    assign w_resp_lsu  = w_resp &&  r_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_req_valid  <= 1'b0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_ifu || w_grant_lsu) begin
                        r_state      <= ISSUE;
                        r_req_valid  <= 1'b1;
                        r_owner      <= w_grant_lsu;
                        r_last_grant <= w_grant_lsu;
                        if (w_grant_lsu) begin
                            r_addr  <= bus.lsu_req_addr;
                            r_wen   <= bus.lsu_req_wen;
                            r_wdata <= bus.lsu_req_wdata;
                            r_wmask <= bus.lsu_req_wmask;
                        end else begin
                            r_addr  <= bus.ifu_req_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_state     <= WAIT_RESP;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready  = w_grant_ifu;
    assign bus.lsu_req_ready  = w_grant_lsu;
    assign bus.ifu_resp_valid = w_resp_ifu;
    assign bus.lsu_resp_valid = w_resp_lsu;
    assign bus.ifu_resp_data  = w_resp_ifu ? bus.mem_resp_data : '0;
    assign bus.lsu_resp_data  = w_resp_lsu ? bus.mem_resp_data : '0;

    assign bus.mem_req_valid  = r_req_valid;
    assign bus.mem_req_addr   = r_addr;
    assign bus.mem_req_wen    = r_wen;
    assign bus.mem_req_wdata  = r_wdata;
    assign bus.mem_req_wmask  = r_wmask;
    assign bus.owner          = r_owner;
endmodule
